// File: rtl/lsu_stbuf_fifo_if.sv
// Store-buffer bus: enqueue side, head/commit handshake and load-forward lookup.
interface lsu_stbuf_fifo_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [BE_W-1:0]   wr_byteen;
  logic              wr_in_pic;

  logic              stbuf_commit;
  logic              stbuf_reqvld_any;
  logic [ADDR_W-1:0] stbuf_addr_any;
  logic [DATA_W-1:0] stbuf_data_any;
  logic              stbuf_addr_in_pic_any;

  logic [ADDR_W-1:0] fwd_addr_lo;
  logic [ADDR_W-1:0] fwd_addr_hi;
  logic              fwd_rden;
  logic [DATA_W-1:0] stbuf_fwddata_lo_dc3;
  logic [DATA_W-1:0] stbuf_fwddata_hi_dc3;
  logic [BE_W-1:0]   stbuf_fwdbyteen_lo_dc3;
  logic [BE_W-1:0]   stbuf_fwdbyteen_hi_dc3;

  logic              stbuf_full;
  logic              stbuf_empty;
  logic              stbuf_ovf_err;

  modport master (
    output wr_en, wr_addr, wr_data, wr_byteen, wr_in_pic,
    output stbuf_commit, fwd_addr_lo, fwd_addr_hi, fwd_rden,
    input  stbuf_reqvld_any, stbuf_addr_any, stbuf_data_any, stbuf_addr_in_pic_any,
    input  stbuf_fwddata_lo_dc3, stbuf_fwddata_hi_dc3,
    input  stbuf_fwdbyteen_lo_dc3, stbuf_fwdbyteen_hi_dc3,
    input  stbuf_full, stbuf_empty, stbuf_ovf_err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_byteen, wr_in_pic,
    input  stbuf_commit, fwd_addr_lo, fwd_addr_hi, fwd_rden,
    output stbuf_reqvld_any, stbuf_addr_any, stbuf_data_any, stbuf_addr_in_pic_any,
    output stbuf_fwddata_lo_dc3, stbuf_fwddata_hi_dc3,
    output stbuf_fwdbyteen_lo_dc3, stbuf_fwdbyteen_hi_dc3,
    output stbuf_full, stbuf_empty, stbuf_ovf_err
  );
endinterface

// File: rtl/lsu_stbuf_fifo.sv
// LSU store buffer: circular FIFO of committed stores that drains to DCCM/PIC
// and forwards bytes to younger loads with a registered dc2->dc3 lookup.
module lsu_stbuf_fifo #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input logic clk,
  input logic rst,
  lsu_stbuf_fifo_if.slave bus
);
  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;
  localparam int BE_W = DATA_W / 8;
  localparam int AW   = ADDR_W - 2;

  logic [DEPTH-1:0]  valid;
  logic [AW-1:0]     ent_addr   [DEPTH];
  logic [DATA_W-1:0] ent_data   [DEPTH];
  logic [BE_W-1:0]   ent_byteen [DEPTH];
  logic [DEPTH-1:0]  ent_in_pic;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          ovf_err;

  logic full;
  logic empty;
  logic enq;
  logic deq;

  logic [DATA_W-1:0] fwd_data_lo_nxt, fwd_data_hi_nxt;
  logic [BE_W-1:0]   fwd_be_lo_nxt, fwd_be_hi_nxt;
  logic [DATA_W-1:0] fwd_data_lo, fwd_data_hi;
  logic [BE_W-1:0]   fwd_be_lo, fwd_be_hi;

  // Byte offsets are don't-care: entries and lookups compare at word granularity.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{bus.wr_addr[1:0], bus.fwd_addr_lo[1:0], bus.fwd_addr_hi[1:0]};

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign deq   = bus.stbuf_commit & valid[rd_ptr];
  // A commit while full frees the head in the same cycle, so the store still fits.
  assign enq   = bus.wr_en & (~full | bus.stbuf_commit);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ovf_err <= 1'b0;
    end else begin
      if (deq) begin
        valid[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + PW'(1);
      end
      if (enq) begin
        valid[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + PW'(1);
      end
      if (enq && !deq) begin
        count <= count + CW'(1);
      end else if (deq && !enq) begin
        count <= count - CW'(1);
      end
      if (bus.wr_en && full && !bus.stbuf_commit) begin
        ovf_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq && !rst) begin
      ent_addr[wr_ptr]   <= bus.wr_addr[ADDR_W-1:2];
      ent_data[wr_ptr]   <= bus.wr_data;
      ent_byteen[wr_ptr] <= bus.wr_byteen;
      ent_in_pic[wr_ptr] <= bus.wr_in_pic;
    end
  end

  assign bus.stbuf_reqvld_any      = valid[rd_ptr];
  assign bus.stbuf_addr_any        = {ent_addr[rd_ptr], 2'b00};
  assign bus.stbuf_data_any        = ent_data[rd_ptr];
  assign bus.stbuf_addr_in_pic_any = ent_in_pic[rd_ptr];
  assign bus.stbuf_full            = full;
  assign bus.stbuf_empty           = empty;
  assign bus.stbuf_ovf_err         = ovf_err;

  // Walk oldest to youngest from rd_ptr so later (younger) matches overwrite earlier ones.
  always_comb begin : fwd_lookup
    logic [PW-1:0] idx;
    logic          hit_lo;
    logic          hit_hi;
    fwd_data_lo_nxt = '0;
    fwd_data_hi_nxt = '0;
    fwd_be_lo_nxt   = '0;
    fwd_be_hi_nxt   = '0;
    idx             = '0;
    hit_lo          = 1'b0;
    hit_hi          = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      idx    = rd_ptr + PW'(k);
      hit_lo = valid[idx] && (ent_addr[idx] == bus.fwd_addr_lo[ADDR_W-1:2]);
      hit_hi = valid[idx] && (ent_addr[idx] == bus.fwd_addr_hi[ADDR_W-1:2]);
      for (int b = 0; b < BE_W; b++) begin
        if (hit_lo && ent_byteen[idx][b]) begin
          fwd_data_lo_nxt[b*8 +: 8] = ent_data[idx][b*8 +: 8];
          fwd_be_lo_nxt[b]          = 1'b1;
        end
        if (hit_hi && ent_byteen[idx][b]) begin
          fwd_data_hi_nxt[b*8 +: 8] = ent_data[idx][b*8 +: 8];
          fwd_be_hi_nxt[b]          = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !bus.fwd_rden) begin
      fwd_data_lo <= '0;
      fwd_data_hi <= '0;
      fwd_be_lo   <= '0;
      fwd_be_hi   <= '0;
    end else begin
      fwd_data_lo <= fwd_data_lo_nxt;
      fwd_data_hi <= fwd_data_hi_nxt;
      fwd_be_lo   <= fwd_be_lo_nxt;
      fwd_be_hi   <= fwd_be_hi_nxt;
    end
  end

  assign bus.stbuf_fwddata_lo_dc3   = fwd_data_lo;
  assign bus.stbuf_fwddata_hi_dc3   = fwd_data_hi;
  assign bus.stbuf_fwdbyteen_lo_dc3 = fwd_be_lo;
  assign bus.stbuf_fwdbyteen_hi_dc3 = fwd_be_hi;

endmodule

// File: tb/tb_lsu_stbuf_fifo.sv
// Directed bench for lsu_stbuf_fifo: vector table plus fill/overflow, wrap and reset sequences.
module tb_lsu_stbuf_fifo;
  logic clk;
  logic rst;

  lsu_stbuf_fifo_if bus ();

  lsu_stbuf_fifo dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        pic;
    logic        commit;
    logic        rden;
    logic [15:0] lo;
    logic [15:0] hi;
    logic        e_reqvld;
    logic [15:0] e_addr;
    logic [31:0] e_data;
    logic        e_pic;
    logic        e_full;
    logic        e_empty;
    logic        e_ovf;
    logic [3:0]  e_lo_be;
    logic [31:0] e_lo_data;
    logic [3:0]  e_hi_be;
    logic [31:0] e_hi_data;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%h expected=%h", name, act, exp);
  endtask

  task automatic idle();
    bus.wr_en        = 1'b0;
    bus.wr_addr      = '0;
    bus.wr_data      = '0;
    bus.wr_byteen    = '0;
    bus.wr_in_pic    = 1'b0;
    bus.stbuf_commit = 1'b0;
    bus.fwd_rden     = 1'b0;
    bus.fwd_addr_lo  = '0;
    bus.fwd_addr_hi  = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] a, input logic [31:0] d, input logic commit);
    idle();
    bus.wr_en        = 1'b1;
    bus.wr_addr      = a;
    bus.wr_data      = d;
    bus.wr_byteen    = 4'hF;
    bus.stbuf_commit = commit;
    step();
  endtask

  initial begin
    // wr_en addr data be pic commit rden lo hi | reqvld addr data pic full empty ovf lo_be lo_data hi_be hi_data
    vecs[0]  = '{1'b1, 16'h0104, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000,
                 1'b1, 16'h0104, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0, 32'h0};
    vecs[1]  = '{1'b0, 16'h0000, 32'h0, 4'h0, 1'b0, 1'b1, 1'b1, 16'h0104, 16'h0300,
                 1'b0, 16'h0000, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'hF, 32'hDEADBEEF, 4'h0, 32'h0};
    vecs[2]  = '{1'b1, 16'h0200, 32'h11223344, 4'hF, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000,
                 1'b1, 16'h0200, 32'h11223344, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0, 32'h0};
    vecs[3]  = '{1'b1, 16'h0200, 32'hAA000000, 4'h8, 1'b0, 1'b0, 1'b1, 16'h0201, 16'h0204,
                 1'b1, 16'h0200, 32'h11223344, 1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 32'h11223344, 4'h0, 32'h0};
    vecs[4]  = '{1'b0, 16'h0000, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, 16'h0201, 16'h0203,
                 1'b1, 16'h0200, 32'h11223344, 1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 32'hAA223344, 4'hF, 32'hAA223344};
    vecs[5]  = '{1'b1, 16'h0300, 32'h55667788, 4'hF, 1'b0, 1'b0, 1'b1, 16'h0300, 16'h0200,
                 1'b1, 16'h0200, 32'h11223344, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 4'hF, 32'hAA223344};
    vecs[6]  = '{1'b0, 16'h0000, 32'h0, 4'h0, 1'b0, 1'b1, 1'b1, 16'h0300, 16'h0400,
                 1'b1, 16'h0200, 32'hAA000000, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 32'h55667788, 4'h0, 32'h0};
    vecs[7]  = '{1'b0, 16'h0000, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 16'h0300, 16'h0300,
                 1'b1, 16'h0300, 32'h55667788, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0, 32'h0};
    vecs[8]  = '{1'b1, 16'h0310, 32'h12345678, 4'h5, 1'b0, 1'b0, 1'b1, 16'h0300, 16'h0310,
                 1'b1, 16'h0300, 32'h55667788, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 32'h55667788, 4'h0, 32'h0};
    vecs[9]  = '{1'b0, 16'h0000, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, 16'h0312, 16'h0300,
                 1'b1, 16'h0300, 32'h55667788, 1'b0, 1'b0, 1'b0, 1'b0, 4'h5, 32'h00340078, 4'hF, 32'h55667788};
    vecs[10] = '{1'b0, 16'h0000, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000,
                 1'b1, 16'h0310, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0, 32'h0};
    vecs[11] = '{1'b0, 16'h0000, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000,
                 1'b0, 16'h0000, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0, 4'h0, 32'h0};
    vecs[12] = '{1'b0, 16'h0000, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000,
                 1'b0, 16'h0000, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0, 4'h0, 32'h0};

    idle();
    rst = 1'b1;
    step();
    step();
    chk("rst_empty",  32'(bus.stbuf_empty), 32'd1);
    chk("rst_full",   32'(bus.stbuf_full), 32'd0);
    chk("rst_reqvld", 32'(bus.stbuf_reqvld_any), 32'd0);
    chk("rst_ovf",    32'(bus.stbuf_ovf_err), 32'd0);
    chk("rst_fwdbe",  32'(bus.stbuf_fwdbyteen_lo_dc3), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      bus.wr_en        = vecs[i].wr_en;
      bus.wr_addr      = vecs[i].wr_addr;
      bus.wr_data      = vecs[i].wr_data;
      bus.wr_byteen    = vecs[i].wr_be;
      bus.wr_in_pic    = vecs[i].pic;
      bus.stbuf_commit = vecs[i].commit;
      bus.fwd_rden     = vecs[i].rden;
      bus.fwd_addr_lo  = vecs[i].lo;
      bus.fwd_addr_hi  = vecs[i].hi;
      step();
      chk($sformatf("v%0d_reqvld", i), 32'(bus.stbuf_reqvld_any), 32'(vecs[i].e_reqvld));
      if (vecs[i].e_reqvld) begin
        chk($sformatf("v%0d_addr", i), 32'(bus.stbuf_addr_any), 32'(vecs[i].e_addr));
        chk($sformatf("v%0d_data", i), bus.stbuf_data_any, vecs[i].e_data);
        chk($sformatf("v%0d_pic", i), 32'(bus.stbuf_addr_in_pic_any), 32'(vecs[i].e_pic));
      end
      chk($sformatf("v%0d_full", i), 32'(bus.stbuf_full), 32'(vecs[i].e_full));
      chk($sformatf("v%0d_empty", i), 32'(bus.stbuf_empty), 32'(vecs[i].e_empty));
      chk($sformatf("v%0d_ovf", i), 32'(bus.stbuf_ovf_err), 32'(vecs[i].e_ovf));
      chk($sformatf("v%0d_lo_be", i), 32'(bus.stbuf_fwdbyteen_lo_dc3), 32'(vecs[i].e_lo_be));
      chk($sformatf("v%0d_lo_data", i), bus.stbuf_fwddata_lo_dc3, vecs[i].e_lo_data);
      chk($sformatf("v%0d_hi_be", i), 32'(bus.stbuf_fwdbyteen_hi_dc3), 32'(vecs[i].e_hi_be));
      chk($sformatf("v%0d_hi_data", i), bus.stbuf_fwddata_hi_dc3, vecs[i].e_hi_data);
    end

    // Wrap: one entry in flight, replaced every cycle across several pointer wraps.
    push(16'h0800, 32'h000000A0, 1'b0);
    chk("wrap_head0", bus.stbuf_data_any, 32'h000000A0);
    for (int i = 1; i < 10; i++) begin
      push(16'h0800 + 16'(4 * i), 32'h000000A0 + 32'(i), 1'b1);
      chk($sformatf("wrap_head%0d", i), bus.stbuf_data_any, 32'h000000A0 + 32'(i));
      chk($sformatf("wrap_addr%0d", i), 32'(bus.stbuf_addr_any), 32'h0800 + 32'(4 * i));
      chk($sformatf("wrap_empty%0d", i), 32'(bus.stbuf_empty), 32'd0);
    end
    idle();
    bus.stbuf_commit = 1'b1;
    step();
    chk("wrap_drained", 32'(bus.stbuf_empty), 32'd1);
    chk("wrap_no_ovf", 32'(bus.stbuf_ovf_err), 32'd0);

    // Fill, overflow drop, then enqueue-with-commit while full.
    for (int i = 0; i < 4; i++) begin
      push(16'h1000 + 16'(4 * i), 32'h000000B0 + 32'(i), 1'b0);
      chk($sformatf("fill_full%0d", i), 32'(bus.stbuf_full), 32'(i == 3));
    end
    push(16'h1FF0, 32'h000000BF, 1'b0);
    chk("ovf_set", 32'(bus.stbuf_ovf_err), 32'd1);
    chk("ovf_full", 32'(bus.stbuf_full), 32'd1);
    chk("ovf_head", bus.stbuf_data_any, 32'h000000B0);
    push(16'h1010, 32'h000000B4, 1'b1);
    chk("fullcommit_full", 32'(bus.stbuf_full), 32'd1);
    chk("fullcommit_head", bus.stbuf_data_any, 32'h000000B1);
    chk("ovf_sticky", 32'(bus.stbuf_ovf_err), 32'd1);
    idle();
    bus.stbuf_commit = 1'b1;
    step();
    chk("drain1_head", bus.stbuf_data_any, 32'h000000B2);
    chk("drain1_full", 32'(bus.stbuf_full), 32'd0);

    // Reset with three entries pending; same-cycle enqueue/commit/lookup ignored.
    idle();
    rst              = 1'b1;
    bus.wr_en        = 1'b1;
    bus.wr_addr      = 16'h1100;
    bus.wr_data      = 32'h0000CCCC;
    bus.wr_byteen    = 4'hF;
    bus.stbuf_commit = 1'b1;
    bus.fwd_rden     = 1'b1;
    bus.fwd_addr_lo  = 16'h1008;
    step();
    chk("mrst_empty",  32'(bus.stbuf_empty), 32'd1);
    chk("mrst_full",   32'(bus.stbuf_full), 32'd0);
    chk("mrst_reqvld", 32'(bus.stbuf_reqvld_any), 32'd0);
    chk("mrst_ovf",    32'(bus.stbuf_ovf_err), 32'd0);
    chk("mrst_fwdbe",  32'(bus.stbuf_fwdbyteen_lo_dc3), 32'd0);
    rst = 1'b0;
    idle();
    bus.fwd_rden    = 1'b1;
    bus.fwd_addr_lo = 16'h1008;
    step();
    chk("post_rst_empty", 32'(bus.stbuf_empty), 32'd1);
    chk("post_rst_nofwd", 32'(bus.stbuf_fwdbyteen_lo_dc3), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/lsu_stbuf_fifo.md
LSU_STBUF_FIFO -- requirements
Module: lsu_stbuf_fifo

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- DEPTH, 4, entry count (power of 2, >=2).
- ADDR_W, 16, DCCM/PIC byte-address width.
- DATA_W, 32, entry data width.
REQ-002 Reset: one clock; reset is synchronous and active-high.
REQ-003 Ports (name, direction, width, meaning) SHALL be:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- wr_en  in  1  enqueue a committed store.
- wr_addr  in  ADDR_W  store address; [1:0] ignored, word-aligned.
- wr_data  in  DATA_W  store data.
- wr_byteen  in  DATA_W/8  byte enables.
- wr_in_pic  in  1  store targets PIC.
- stbuf_commit  in  1  head accepted by DCCM/PIC port.
- stbuf_reqvld_any  out  1  head valid.
- stbuf_addr_any  out  ADDR_W  head address (aligned).
- stbuf_data_any  out  DATA_W  head data.
- stbuf_addr_in_pic_any  out  1  head targets PIC.
- fwd_addr_lo, fwd_addr_hi  in  ADDR_W  load start/end address (dc2).
- fwd_rden  in  1  load lookup valid (dc2).
- stbuf_fwddata_lo_dc3, stbuf_fwddata_hi_dc3  out  DATA_W  forwarded data.
- stbuf_fwdbyteen_lo_dc3, stbuf_fwdbyteen_hi_dc3  out  DATA_W/8  forwarded byte enables.
- stbuf_full  out  1  all entries valid.
- stbuf_empty  out  1  no entries valid.
- stbuf_ovf_err  out  1  sticky: enqueue dropped while full.

Function
REQ-004 Storage SHALL be a circular FIFO: per entry valid, addr, data, byteen, in_pic; wr_ptr and rd_ptr of log2(DEPTH) bits wrapping DEPTH-1 -> 0; count of log2(DEPTH)+1 bits.
REQ-005 Enqueue SHALL occur when wr_en & (~stbuf_full | stbuf_commit): write entry at wr_ptr, set valid, wr_ptr+1.
REQ-006 When wr_en & stbuf_full & ~stbuf_commit, the store SHALL be dropped and stbuf_ovf_err set; it stays set until rst.
REQ-007 Dequeue SHALL occur when stbuf_commit & stbuf_reqvld_any: clear valid at rd_ptr, rd_ptr+1; stbuf_commit while empty SHALL be ignored.
REQ-008 Simultaneous enqueue and dequeue SHALL leave count unchanged; when full, the freed head slot takes the new entry in the same cycle.
REQ-009 Head outputs SHALL be combinational from the entry at rd_ptr; stbuf_reqvld_any = valid[rd_ptr]; a store enqueued into an empty FIFO is presented the following cycle.
REQ-010 stbuf_full = (count == DEPTH); stbuf_empty = (count == 0); both derived from registered state.
REQ-011 Forwarding: an entry matches a lookup when valid and addr[ADDR_W-1:2] equals the lookup address [ADDR_W-1:2]; lo and hi lookups are evaluated independently.
REQ-012 Per byte, the youngest matching entry with that byteen bit set SHALL supply the byte and set the fwdbyteen bit; bytes with no match SHALL output data 0, byteen 0.
REQ-013 Forward results SHALL be registered: dc2 lookup -> dc3 outputs, 1-cycle latency; when fwd_rden=0 the registered byteen SHALL be 0.
REQ-014 An entry dequeued in the lookup cycle SHALL still forward; an entry enqueued in the lookup cycle SHALL NOT forward (the upstream stage stalls dependent loads one cycle).
REQ-015 ECC for stbuf_data_any SHALL be generated outside this block.

Reset
REQ-016 On rst=1 at a clk edge: all valid bits, wr_ptr, rd_ptr and count = 0, stbuf_ovf_err = 0, forward output registers = 0; entry payload is not reset.
REQ-017 Reset asserted mid-operation SHALL discard all pending stores; wr_en and stbuf_commit in that cycle are ignored.
REQ-018 After reset: stbuf_empty=1, stbuf_full=0, stbuf_reqvld_any=0.

Verification
REQ-019 Enqueue addr 0x0104, data 0xDEADBEEF, byteen 4'hF into an empty FIFO -> next cycle stbuf_reqvld_any=1, stbuf_addr_any=0x0104, stbuf_data_any=0xDEADBEEF; assert stbuf_commit -> stbuf_empty=1 the cycle after.
REQ-020 Fill 4 entries -> stbuf_full=1; wr_en without commit -> stbuf_ovf_err=1, count stays 4; wr_en with commit -> entry accepted, stbuf_full stays 1.
REQ-021 Entries addr 0x0200 data 0x11223344 byteen 4'hF, then addr 0x0200 data 0xAA000000 byteen 4'h8; lookup lo=0x0201 -> dc3 fwddata_lo=0xAA223344, fwdbyteen_lo=4'hF.
REQ-022 Wrap-around: 10 enqueue/commit pairs -> head order preserved across pointer wrap, no ovf.
REQ-023 Lookup in the same cycle as enqueue to the same address -> fwdbyteen=0; the same lookup one cycle later -> fwdbyteen=4'hF.
REQ-024 Assert rst with 3 valid entries -> next cycle stbuf_empty=1, fwd byteen=0, stbuf_ovf_err=0.
